// File: rtl/rvv_alu_seq.sv
// rvv_alu_seq: multi-cycle RVV integer ALU (vadd/vsub/vrsub/vand/vor/vxor).
// One CHUNK = NB_LANES*LANE_W bits of the vector group is produced per cycle.
// The carry chain runs at byte granularity. A byte takes the element carry-in
// when it starts an element; otherwise it takes the carry from the byte below.
// Byte 0 of a chunk takes the registered carry from the previous chunk.
// This gives the same result as LANE_W slices chained and cut at SEW boundaries.
// Tail elements (index >= clamped vl) keep the latched vd_old contents.
module rvv_alu_seq #(
  parameter int VLEN     = 128,
  parameter int LANE_W   = 32,
  parameter int NB_LANES = 2,
  localparam int VL_W    = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [5:0]        opcode,
  input  logic [2:0]        op_type,
  input  logic [2:0]        vsew,
  input  logic [VL_W-1:0]   vl,
  input  logic [VLEN-1:0]   vs1,
  input  logic [VLEN-1:0]   vs2,
  input  logic [63:0]       scalar,
  input  logic [VLEN-1:0]   vd_old,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [VLEN-1:0]   vd
);

  localparam int CHUNK  = NB_LANES * LANE_W;
  localparam int NCHUNK = VLEN / CHUNK;
  localparam int NBYTE  = VLEN / 8;
  localparam int CBYTE  = CHUNK / 8;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] OP_VADD  = 6'b000000;
  localparam logic [5:0] OP_VSUB  = 6'b000010;
  localparam logic [5:0] OP_VRSUB = 6'b000011;
  localparam logic [5:0] OP_VAND  = 6'b001001;
  localparam logic [5:0] OP_VOR   = 6'b001010;
  localparam logic [5:0] OP_VXOR  = 6'b001011;

  localparam logic [2:0] T_VV = 3'b001;
  localparam logic [2:0] T_VX = 3'b010;
  localparam logic [2:0] T_VI = 3'b100;

  logic [1:0]      state;
  logic [KW-1:0]   k_r;
  logic            carry_r;
  logic [5:0]      op_r;
  logic [1:0]      sew_r;
  logic [VL_W-1:0] vl_r;
  logic [VLEN-1:0] vs2_r;
  logic [VLEN-1:0] b_r;
  logic [VLEN-1:0] old_r;

  // Start-time decode: legality, vl clamp and operand-B broadcast.
  logic            legal;
  logic [VL_W-1:0] vlmax;
  logic [VL_W-1:0] vl_clamp;
  logic [63:0]     scal_ext;
  logic [VLEN-1:0] b_vec;

  // Classify the incoming instruction and clamp vl to VLMAX.
  always_comb begin
    logic op_ok;
    logic type_ok;
    op_ok   = (opcode == OP_VADD)  || (opcode == OP_VSUB) ||
              (opcode == OP_VRSUB) || (opcode == OP_VAND) ||
              (opcode == OP_VOR)   || (opcode == OP_VXOR);
    type_ok = (op_type == T_VV) || (op_type == T_VX) || (op_type == T_VI);
    legal   = op_ok && type_ok && !vsew[2] &&
              !((op_type == T_VI) && (opcode == OP_VSUB));
    vlmax    = VL_W'(NBYTE) >> vsew[1:0];
    vl_clamp = (vl > vlmax) ? vlmax : vl;
  end

  // Build the full-width operand B: vs1 for VV, or the scalar/imm repeated per element.
  always_comb begin
    logic [2:0] sel;
    scal_ext = (op_type == T_VI) ? {{59{scalar[4]}}, scalar[4:0]} : scalar;
    b_vec    = '0;
    sel      = '0;
    for (int unsigned i = 0; i < NBYTE; i++) begin
      sel = 3'(i) & ((3'd1 << vsew[1:0]) - 3'd1);
      if (op_type == T_VV)
        b_vec[i*8 +: 8] = vs1[i*8 +: 8];
      else
        b_vec[i*8 +: 8] = scal_ext[sel*8 +: 8];
    end
  end

  // Per-chunk datapath.
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] old_ch;
  logic [CHUNK-1:0] res;
  logic             carry_nx;
  logic [VL_W-1:0]  lsb_mask;

  // Select the chunk currently being processed from the latched operands.
  always_comb begin
    a_ch     = vs2_r[k_r*CHUNK +: CHUNK];
    b_ch     = b_r[k_r*CHUNK +: CHUNK];
    old_ch   = old_r[k_r*CHUNK +: CHUNK];
    lsb_mask = (VL_W'(1) << sew_r) - VL_W'(1);
  end

  // Byte-sliced add/sub/rsub/logic with the carry cut at element boundaries.
  always_comb begin
    logic [VL_W-1:0] gb;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [7:0]      x;
    logic [7:0]      y;
    logic [7:0]      s;
    logic [8:0]      t;
    logic            c;
    logic            cin0;
    res      = '0;
    carry_nx = 1'b0;
    gb       = '0;
    a        = '0;
    b        = '0;
    x        = '0;
    y        = '0;
    s        = '0;
    t        = '0;
    c        = carry_r;
    cin0     = (op_r == OP_VSUB) || (op_r == OP_VRSUB);
    for (int unsigned j = 0; j < CBYTE; j++) begin
      gb = VL_W'(k_r) * VL_W'(CBYTE) + VL_W'(j);
      a  = a_ch[j*8 +: 8];
      b  = b_ch[j*8 +: 8];
      if ((gb & lsb_mask) == '0)
        c = cin0;
      case (op_r)
        OP_VSUB:  begin x = a; y = ~b; end
        OP_VRSUB: begin x = b; y = ~a; end
        default:  begin x = a; y = b;  end
      endcase
      t = {1'b0, x} + {1'b0, y} + {8'b0, c};
      case (op_r)
        OP_VAND: s = a & b;
        OP_VOR:  s = a | b;
        OP_VXOR: s = a ^ b;
        default: s = t[7:0];
      endcase
      c = t[8];
      if ((gb >> sew_r) >= vl_r)
        res[j*8 +: 8] = old_ch[j*8 +: 8];
      else
        res[j*8 +: 8] = s;
    end
    carry_nx = c;
  end

  // Control FSM, operand latching and chunk-by-chunk result write-back.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      vd      <= '0;
      carry_r <= 1'b0;
      k_r     <= '0;
      op_r    <= '0;
      sew_r   <= '0;
      vl_r    <= '0;
      vs2_r   <= '0;
      b_r     <= '0;
      old_r   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state   <= S_IDLE;
          done    <= 1'b0;
          illegal <= 1'b0;
          if (start) begin
            op_r  <= opcode;
            sew_r <= vsew[1:0];
            vl_r  <= vl_clamp;
            vs2_r <= vs2;
            b_r   <= b_vec;
            old_r <= vd_old;
            if (legal) begin
              state   <= S_RUN;
              busy    <= 1'b1;
              k_r     <= '0;
              carry_r <= 1'b0;
            end else begin
              state   <= S_DONE;
              done    <= 1'b1;
              illegal <= 1'b1;
            end
          end
        end
        S_RUN: begin
          vd[k_r*CHUNK +: CHUNK] <= res;
          carry_r <= carry_nx;
          if (k_r == KW'(NCHUNK-1)) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            illegal <= 1'b0;
          end else begin
            k_r <= k_r + KW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_alu_seq.sv
// Scoreboard bench for rvv_alu_seq: two instances (NCHUNK=2 and NCHUNK=4)
// receive the same directed instructions; monitors check vd/illegal/latency.
module tb_rvv_alu_seq;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   opcode = '0;
  logic [2:0]   op_type = '0;
  logic [2:0]   vsew = '0;
  logic [4:0]   vl = '0;
  logic [127:0] vs1 = '0;
  logic [127:0] vs2 = '0;
  logic [63:0]  scalar = '0;
  logic [127:0] vd_old = '0;

  logic         busy0, done0, ill0;
  logic [127:0] vd0;
  logic         busy1, done1, ill1;
  logic [127:0] vd1;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [127:0] vd;
    logic         ill;
    int           cyc;
    string        nm;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  rvv_alu_seq #(.VLEN(128), .LANE_W(32), .NB_LANES(2)) u0 (
    .clk(clk), .resetn(resetn), .start(start), .opcode(opcode),
    .op_type(op_type), .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2),
    .scalar(scalar), .vd_old(vd_old), .busy(busy0), .done(done0),
    .illegal(ill0), .vd(vd0)
  );

  rvv_alu_seq #(.VLEN(128), .LANE_W(32), .NB_LANES(1)) u1 (
    .clk(clk), .resetn(resetn), .start(start), .opcode(opcode),
    .op_type(op_type), .vsew(vsew), .vl(vl), .vs1(vs1), .vs2(vs2),
    .scalar(scalar), .vd_old(vd_old), .busy(busy1), .done(done1),
    .illegal(ill1), .vd(vd1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor for the 2-chunk instance.
  always @(negedge clk) begin
    if (resetn && done0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL u0 unexpected_done vd=%h ill=%b cyc=%0d required no done", vd0, ill0, cyc);
      end else begin
        e0 = q0.pop_front();
        if (vd0 !== e0.vd || ill0 !== e0.ill || cyc != e0.cyc) begin
          bad++;
          $display("FAIL u0 %s vd=%h ill=%b cyc=%0d required vd=%h ill=%b cyc=%0d",
                   e0.nm, vd0, ill0, cyc, e0.vd, e0.ill, e0.cyc);
        end
      end
    end
  end

  // Monitor for the 4-chunk instance.
  always @(negedge clk) begin
    if (resetn && done1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL u1 unexpected_done vd=%h ill=%b cyc=%0d required no done", vd1, ill1, cyc);
      end else begin
        e1 = q1.pop_front();
        if (vd1 !== e1.vd || ill1 !== e1.ill || cyc != e1.cyc) begin
          bad++;
          $display("FAIL u1 %s vd=%h ill=%b cyc=%0d required vd=%h ill=%b cyc=%0d",
                   e1.nm, vd1, ill1, cyc, e1.vd, e1.ill, e1.cyc);
        end
      end
    end
  end

  task automatic scramble();
    vs1    = {$urandom, $urandom, $urandom, $urandom};
    vs2    = {$urandom, $urandom, $urandom, $urandom};
    vd_old = {$urandom, $urandom, $urandom, $urandom};
    scalar = {$urandom, $urandom};
    opcode = 6'($urandom);
    vl     = 5'($urandom);
  endtask

  task automatic issue(input string nm, input logic [5:0] op, input logic [2:0] ty,
                       input logic [2:0] sew, input logic [4:0] vlv,
                       input logic [127:0] a1, input logic [127:0] a2,
                       input logic [63:0] sc, input logic [127:0] old,
                       input logic [127:0] ev, input logic ei);
    @(negedge clk);
    opcode = op; op_type = ty; vsew = sew; vl = vlv;
    vs1 = a1; vs2 = a2; scalar = sc; vd_old = old;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    q0.push_back('{ev, ei, ei ? cyc : cyc + 2, nm});
    q1.push_back('{ev, ei, ei ? cyc : cyc + 4, nm});
    total++;
    if (busy0 !== !ei || busy1 !== !ei) begin
      bad++;
      $display("FAIL %s busy u0=%b u1=%b required %b", nm, busy0, busy1, !ei);
    end
    scramble();
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout pending u0=%0d u1=%0d required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic check_idle_zero(input string nm);
    total++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || ill0 !== 1'b0 || vd0 !== '0 ||
        busy1 !== 1'b0 || done1 !== 1'b0 || ill1 !== 1'b0 || vd1 !== '0) begin
      bad++;
      $display("FAIL %s u0 b/d/i=%b%b%b vd=%h u1 b/d/i=%b%b%b vd=%h required all zero",
               nm, busy0, done0, ill0, vd0, busy1, done1, ill1, vd1);
    end
  endtask

  localparam logic [127:0] XOR_VL9 = 128'hEEEE2222_CCCC4444_5A5A6969_87877878;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    issue("vadd_vv_sew8", 6'b000000, 3'b001, 3'd0, 5'd16, {16{8'h01}}, {16{8'hFF}},
          64'h0, {16{8'h33}}, 128'h0, 1'b0);
    drain();
    issue("vadd_vv_sew64", 6'b000000, 3'b001, 3'd3, 5'd2, {2{64'h1}},
          {2{64'h0000_0000_FFFF_FFFF}}, 64'h0, '0, {2{64'h0000_0001_0000_0000}}, 1'b0);
    drain();
    issue("vadd_vv_sew64_vlclamp", 6'b000000, 3'b001, 3'd3, 5'd9, {2{64'h1}},
          {2{64'h0000_0000_FFFF_FFFF}}, 64'h0, '1, {2{64'h0000_0001_0000_0000}}, 1'b0);
    drain();
    issue("vsub_vx_sew32", 6'b000010, 3'b010, 3'd2, 5'd4, '0, {4{32'd5}},
          64'h7, '0, {4{32'hFFFF_FFFE}}, 1'b0);
    drain();
    issue("vrsub_vi_sew16", 6'b000011, 3'b100, 3'd1, 5'd8, '0, {8{16'h0001}},
          64'h0000_0000_0000_001F, '0, {8{16'hFFFE}}, 1'b0);
    drain();
    issue("vsub_vv_sew8", 6'b000010, 3'b001, 3'd0, 5'd16, {16{8'h01}}, '0,
          64'h0, '0, {16{8'hFF}}, 1'b0);
    drain();
    issue("vadd_vx_sew16", 6'b000000, 3'b010, 3'd1, 5'd8, '0, {8{16'h00FF}},
          64'hFFFF_FFFF_FFFF_0001, '0, {8{16'h0100}}, 1'b0);
    drain();
    issue("vor_vx_sew8_tail", 6'b001010, 3'b010, 3'd0, 5'd3, '1, {16{8'h30}},
          64'h0F, '0, 128'h0000_0000_0000_0000_0000_0000_003F_3F3F, 1'b0);
    drain();
    issue("vand_vi_sew16", 6'b001001, 3'b100, 3'd1, 5'd8, '0, {8{16'h1234}},
          64'h10, '0, {8{16'h1230}}, 1'b0);
    drain();
    issue("vadd_vl0", 6'b000000, 3'b001, 3'd0, 5'd0, {16{8'h11}}, {16{8'h22}},
          64'h0, 128'h0123456789ABCDEF_FEDCBA9876543210,
          128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    drain();
    issue("vxor_vv_vl2", 6'b001011, 3'b001, 3'd2, 5'd2,
          128'hFFFF0000_FFFF0000_0F0F0F0F_F0F0F0F0,
          128'h11112222_33334444_55556666_77778888, 64'h0, {16{8'hA5}},
          128'hA5A5A5A5_A5A5A5A5_5A5A6969_87877878, 1'b0);
    drain();
    issue("vxor_vv_vl9", 6'b001011, 3'b001, 3'd2, 5'd9,
          128'hFFFF0000_FFFF0000_0F0F0F0F_F0F0F0F0,
          128'h11112222_33334444_55556666_77778888, 64'h0, {16{8'hA5}},
          XOR_VL9, 1'b0);
    drain();
    issue("ill_vsub_vi", 6'b000010, 3'b100, 3'd0, 5'd16, '1, '1, 64'h1, '0, XOR_VL9, 1'b1);
    drain();
    issue("ill_opcode", 6'b000101, 3'b001, 3'd0, 5'd16, '1, '1, 64'h1, '0, XOR_VL9, 1'b1);
    drain();
    issue("ill_optype", 6'b000000, 3'b011, 3'd0, 5'd16, '1, '1, 64'h1, '0, XOR_VL9, 1'b1);
    drain();
    issue("ill_vsew", 6'b000000, 3'b001, 3'd4, 5'd16, '1, '1, 64'h1, '0, XOR_VL9, 1'b1);
    drain();

    // A second start while busy must be ignored: one done, first result only.
    issue("busy_ignore", 6'b000000, 3'b001, 3'd2, 5'd4, {4{32'd2}}, {4{32'd1}},
          64'h0, '0, {4{32'd3}}, 1'b0);
    @(negedge clk);
    opcode = 6'b001011; op_type = 3'b001; vsew = 3'd0; vl = 5'd16;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    @(negedge clk);
    opcode = 6'b000000; op_type = 3'b001; vsew = 3'd0; vl = 5'd16;
    vs1 = {16{8'h01}}; vs2 = {16{8'h01}};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_idle_zero("reset_mid_run");
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_zero("after_abort");

    issue("after_reset", 6'b000000, 3'b001, 3'd3, 5'd2, {2{64'h1}},
          {2{64'h0000_0000_FFFF_FFFF}}, 64'h0, '0, {2{64'h0000_0001_0000_0000}}, 1'b0);
    drain();
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
